// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Shares one memory request/response channel between the L1 I-cache miss
//   path and the L1 D-cache miss path. Miss requests are arbitrated
//   round-robin, only while idle. The winning request is held in registers
//   and offered to memory with a valid/ready handshake, tagged with its
//   source. Line-fill responses are routed back to the owning cache by that
//   tag. Each source may have at most one miss outstanding.
//
// Ports
//   clk               : clock, rising edge
//   reset             : asynchronous active-low reset
//   ic_req_valid_i    : I-cache miss request
//   ic_req_addr_i     : I-cache miss block address
//   ic_req_ready_o    : I-cache request accepted this cycle (combinational)
//   dc_req_valid_i    : D-cache miss request
//   dc_req_addr_i     : D-cache miss block address
//   dc_req_ready_o    : D-cache request accepted this cycle (combinational)
//   mem_req_valid_o   : request to memory
//   mem_req_addr_o    : block address to memory
//   mem_req_src_o     : source tag, 0 = I, 1 = D
//   mem_req_ready_i   : memory accepts the request
//   mem_resp_valid_i  : fill response valid
//   mem_resp_src_i    : source tag echoed by memory
//   mem_resp_data_i   : fill line
//   ic_resp_valid_o   : one-cycle fill pulse for the I-cache
//   ic_resp_data_o    : I-cache fill line (meaningful while valid)
//   dc_resp_valid_o   : one-cycle fill pulse for the D-cache
//   dc_resp_data_o    : D-cache fill line (meaningful while valid)
//   spurious_o        : sticky, a fill arrived for a source with no miss outstanding

module l1_mem_arbiter #(
    parameter int ADDR_BITS = 26,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req_valid_i,
    input  logic [ADDR_BITS-1:0] ic_req_addr_i,
    output logic                 ic_req_ready_o,
    input  logic                 dc_req_valid_i,
    input  logic [ADDR_BITS-1:0] dc_req_addr_i,
    output logic                 dc_req_ready_o,
    output logic                 mem_req_valid_o,
    output logic [ADDR_BITS-1:0] mem_req_addr_o,
    output logic                 mem_req_src_o,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_resp_valid_i,
    input  logic                 mem_resp_src_i,
    input  logic [LINE_BITS-1:0] mem_resp_data_i,
    output logic                 ic_resp_valid_o,
    output logic [LINE_BITS-1:0] ic_resp_data_o,
    output logic                 dc_resp_valid_o,
    output logic [LINE_BITS-1:0] dc_resp_data_o,
    output logic                 spurious_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    // Tie-break: when both sources are eligible the one not granted last wins.
    // Returns 1 when the D-cache should win this cycle.
    function automatic logic pick_dc(input logic ic_elig, input logic dc_elig,
                                     input logic last_grant);
        logic res;
        if (ic_elig && dc_elig) begin
            res = (last_grant == SRC_I);
        end else begin
            res = dc_elig;
        end
        return res;
    endfunction

    state_t                 r_state;
    logic                   r_mem_req_valid;
    logic [ADDR_BITS-1:0]   r_req_addr;
    logic                   r_req_src;
    logic                   r_last_grant;
    logic                   r_ic_out;
    logic                   r_dc_out;
    logic                   r_ic_resp_valid;
    logic                   r_dc_resp_valid;
    logic [LINE_BITS-1:0]   r_ic_resp_data;
    logic [LINE_BITS-1:0]   r_dc_resp_data;
    logic                   r_spurious;

    logic                   w_ic_elig;
    logic                   w_dc_elig;
    logic                   w_grant_ic;
    logic                   w_grant_dc;
    logic                   w_ic_hit;
    logic                   w_dc_hit;
    logic                   w_resp_drop;

    // Eligibility and grant selection; grants are only ever issued from IDLE.
    always_comb begin
        w_ic_elig  = ic_req_valid_i & ~r_ic_out;
        w_dc_elig  = dc_req_valid_i & ~r_dc_out;
        w_grant_ic = 1'b0;
        w_grant_dc = 1'b0;
        if ((r_state == ST_IDLE) && (w_ic_elig || w_dc_elig)) begin
            if (pick_dc(w_ic_elig, w_dc_elig, r_last_grant)) begin
                w_grant_dc = 1'b1;
            end else begin
                w_grant_ic = 1'b1;
            end
        end else begin
            w_grant_ic = 1'b0;
            w_grant_dc = 1'b0;
        end
    end

    // Response classification: a fill is accepted only if its tagged source
    // really has a miss in flight, otherwise it is dropped and flagged.
    always_comb begin
        w_ic_hit    = 1'b0;
        w_dc_hit    = 1'b0;
        w_resp_drop = 1'b0;
        if (mem_resp_valid_i) begin
            if (mem_resp_src_i == SRC_D) begin
                w_dc_hit    = r_dc_out;
                w_resp_drop = ~r_dc_out;
            end else begin
                w_ic_hit    = r_ic_out;
                w_resp_drop = ~r_ic_out;
            end
        end else begin
            w_ic_hit    = 1'b0;
            w_dc_hit    = 1'b0;
            w_resp_drop = 1'b0;
        end
    end

    // Request FSM: capture the winner in IDLE, hold it stable during ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_mem_req_valid <= 1'b0;
            r_req_addr      <= {ADDR_BITS{1'b0}};
            r_req_src       <= SRC_I;
            r_last_grant    <= SRC_D;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dc) begin
                        r_state         <= ST_ISSUE;
                        r_mem_req_valid <= 1'b1;
                        r_req_addr      <= dc_req_addr_i;
                        r_req_src       <= SRC_D;
                        r_last_grant    <= SRC_D;
                    end else if (w_grant_ic) begin
                        r_state         <= ST_ISSUE;
                        r_mem_req_valid <= 1'b1;
                        r_req_addr      <= ic_req_addr_i;
                        r_req_src       <= SRC_I;
                        r_last_grant    <= SRC_I;
                    end else begin
                        r_state         <= ST_IDLE;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready_i) begin
                        r_state         <= ST_IDLE;
                        r_mem_req_valid <= 1'b0;
                    end else begin
                        r_state         <= ST_ISSUE;
                        r_mem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding-miss flags. A grant needs the flag clear and a hit needs it
    // set, so the two can never target the same source in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ic_out <= 1'b0;
            r_dc_out <= 1'b0;
        end else begin
            if (w_grant_ic) begin
                r_ic_out <= 1'b1;
            end else if (w_ic_hit) begin
                r_ic_out <= 1'b0;
            end else begin
                r_ic_out <= r_ic_out;
            end
            if (w_grant_dc) begin
                r_dc_out <= 1'b1;
            end else if (w_dc_hit) begin
                r_dc_out <= 1'b0;
            end else begin
                r_dc_out <= r_dc_out;
            end
        end
    end

    // Fill routing: register the line for its owner and pulse that valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ic_resp_valid <= 1'b0;
            r_dc_resp_valid <= 1'b0;
            r_ic_resp_data  <= {LINE_BITS{1'b0}};
            r_dc_resp_data  <= {LINE_BITS{1'b0}};
        end else begin
            r_ic_resp_valid <= w_ic_hit;
            r_dc_resp_valid <= w_dc_hit;
            if (w_ic_hit) begin
                r_ic_resp_data <= mem_resp_data_i;
            end
            if (w_dc_hit) begin
                r_dc_resp_data <= mem_resp_data_i;
            end
        end
    end

    // Sticky spurious-fill flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spurious <= 1'b0;
        end else if (w_resp_drop) begin
            r_spurious <= 1'b1;
        end
    end

    assign ic_req_ready_o  = w_grant_ic;
    assign dc_req_ready_o  = w_grant_dc;
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_req_addr_o  = r_req_addr;
    assign mem_req_src_o   = r_req_src;
    assign ic_resp_valid_o = r_ic_resp_valid;
    assign ic_resp_data_o  = r_ic_resp_data;
    assign dc_resp_valid_o = r_dc_resp_valid;
    assign dc_resp_data_o  = r_dc_resp_data;
    assign spurious_o      = r_spurious;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: a table of per-cycle vectors,
// followed by hand-written round-robin, backpressure and reset sequences.
// Memory requests and fills are checked through scoreboard queues.
module tb_l1_mem_arbiter;
    localparam int AB = 26;
    localparam int LB = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid_i, dc_req_valid_i;
    logic [AB-1:0] ic_req_addr_i, dc_req_addr_i;
    logic          ic_req_ready_o, dc_req_ready_o;
    logic          mem_req_valid_o, mem_req_src_o, mem_req_ready_i;
    logic [AB-1:0] mem_req_addr_o;
    logic          mem_resp_valid_i, mem_resp_src_i;
    logic [LB-1:0] mem_resp_data_i;
    logic          ic_resp_valid_o, dc_resp_valid_o, spurious_o;
    logic [LB-1:0] ic_resp_data_o, dc_resp_data_o;

    always #5 clk = ~clk;

    l1_mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_ready_o(ic_req_ready_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i), .dc_req_ready_o(dc_req_ready_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_src_o(mem_req_src_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_src_i(mem_resp_src_i), .mem_resp_data_i(mem_resp_data_i),
        .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
        .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_data_o(dc_resp_data_o),
        .spurious_o(spurious_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [AB-1:0] addr; logic src; } req_t;
    typedef struct packed { logic src; logic [LB-1:0] data; } rsp_t;
    req_t req_q[$];
    rsp_t rsp_q[$];

    // Scoreboard monitor: memory handshakes and fill pulses are popped here.
    always @(negedge clk) begin : monitor
        req_t e_req;
        rsp_t e_rsp;
        if (reset === 1'b1) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_mem_req", LB'(mem_req_addr_o), LB'(0));
                end else begin
                    e_req = req_q.pop_front();
                    chk("mem_req_addr", LB'(mem_req_addr_o), LB'(e_req.addr));
                    chk("mem_req_src", LB'(mem_req_src_o), LB'(e_req.src));
                end
            end
            if (ic_resp_valid_o || dc_resp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_fill", LB'({ic_resp_valid_o, dc_resp_valid_o}), LB'(0));
                end else begin
                    e_rsp = rsp_q.pop_front();
                    chk("fill_route", LB'({ic_resp_valid_o, dc_resp_valid_o}),
                        LB'(e_rsp.src ? 2'b01 : 2'b10));
                    chk("fill_data", e_rsp.src ? dc_resp_data_o : ic_resp_data_o, e_rsp.data);
                end
            end
        end
    end

    typedef struct {
        logic          ic_v;  logic [AB-1:0] ic_a;
        logic          dc_v;  logic [AB-1:0] dc_a;
        logic          m_rdy; logic r_v; logic r_src; logic [31:0] r_pat; logic r_hit;
        logic          e_ic_rdy, e_dc_rdy, e_mem_v, e_ic_rv, e_dc_rv, e_spur;
    } vec_t;

    function automatic vec_t mk(input logic icv, input logic [AB-1:0] ica, input logic dcv,
                                input logic [AB-1:0] dca, input logic mr, input logic rv,
                                input logic rs, input logic [31:0] pat, input logic hit,
                                input logic eir, input logic edr, input logic emv,
                                input logic eicv, input logic edcv, input logic esp);
        vec_t v;
        v.ic_v = icv; v.ic_a = ica; v.dc_v = dcv; v.dc_a = dca; v.m_rdy = mr;
        v.r_v = rv; v.r_src = rs; v.r_pat = pat; v.r_hit = hit;
        v.e_ic_rdy = eir; v.e_dc_rdy = edr; v.e_mem_v = emv;
        v.e_ic_rv = eicv; v.e_dc_rv = edcv; v.e_spur = esp;
        return v;
    endfunction

    task automatic drive(input logic icv, input logic [AB-1:0] ica, input logic dcv,
                         input logic [AB-1:0] dca, input logic mr, input logic rv,
                         input logic rs, input logic [LB-1:0] rd);
        ic_req_valid_i   = icv; ic_req_addr_i = ica;
        dc_req_valid_i   = dcv; dc_req_addr_i = dca;
        mem_req_ready_i  = mr;
        mem_resp_valid_i = rv;  mem_resp_src_i = rs; mem_resp_data_i = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, check the cleared outputs, release after the next edge.
    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        req_q.delete();
        rsp_q.delete();
        #1;
        chk("rst_mem_valid", LB'(mem_req_valid_o), LB'(0));
        chk("rst_spurious", LB'(spurious_o), LB'(0));
        chk("rst_fill_valids", LB'({ic_resp_valid_o, dc_resp_valid_o}), LB'(0));
        step();
        reset = 1'b1;
    endtask

    vec_t vt[12];

    initial begin
        req_t r;
        rsp_t p;
        int   hs, ic_cd, dc_cd, rsp_n;
        logic rv, rs;
        logic [LB-1:0] rd;

        vt[0]  = mk(1'b0, 26'h0,     1'b0, 26'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[1]  = mk(1'b1, 26'h12345, 1'b0, 26'h0,     1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 26'h0,     1'b0, 26'h0,     1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[3]  = mk(1'b1, 26'h12345, 1'b1, 26'h0ABCD, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[4]  = mk(1'b1, 26'h12345, 1'b1, 26'h0ABCD, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[5]  = mk(1'b1, 26'h12345, 1'b1, 26'h0ABCD, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[6]  = mk(1'b1, 26'h12345, 1'b1, 26'h0ABCD, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[7]  = mk(1'b1, 26'h12345, 1'b1, 26'h0ABCD, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 26'h0,     1'b0, 26'h0,     1'b1, 1'b1, 1'b1, 32'h3C3C3C3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 26'h0,     1'b0, 26'h0,     1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vt[10] = mk(1'b0, 26'h0,     1'b0, 26'h0,     1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vt[11] = mk(1'b0, 26'h0,     1'b0, 26'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Table-driven phase: single I miss, outstanding block, fills, spurious fill.
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].ic_v, vt[i].ic_a, vt[i].dc_v, vt[i].dc_a, vt[i].m_rdy,
                  vt[i].r_v, vt[i].r_src, {8{vt[i].r_pat}});
            #1;
            chk($sformatf("v%0d_ic_ready", i), LB'(ic_req_ready_o), LB'(vt[i].e_ic_rdy));
            chk($sformatf("v%0d_dc_ready", i), LB'(dc_req_ready_o), LB'(vt[i].e_dc_rdy));
            chk($sformatf("v%0d_mem_valid", i), LB'(mem_req_valid_o), LB'(vt[i].e_mem_v));
            chk($sformatf("v%0d_ic_fill", i), LB'(ic_resp_valid_o), LB'(vt[i].e_ic_rv));
            chk($sformatf("v%0d_dc_fill", i), LB'(dc_resp_valid_o), LB'(vt[i].e_dc_rv));
            chk($sformatf("v%0d_spurious", i), LB'(spurious_o), LB'(vt[i].e_spur));
            if (vt[i].e_ic_rdy) begin r.addr = vt[i].ic_a; r.src = 1'b0; req_q.push_back(r); end
            if (vt[i].e_dc_rdy) begin r.addr = vt[i].dc_a; r.src = 1'b1; req_q.push_back(r); end
            if (vt[i].r_hit) begin p.src = vt[i].r_src; p.data = {8{vt[i].r_pat}}; rsp_q.push_back(p); end
            step();
        end
        step();
        chk("table_req_q_empty", LB'(req_q.size()), LB'(0));
        chk("table_rsp_q_empty", LB'(rsp_q.size()), LB'(0));

        // Tie after reset then round-robin: grants must alternate I, D, I, D, ...
        do_reset();
        for (int k = 0; k < 6; k++) begin
            r.addr = (k % 2 == 0) ? 26'h100 : 26'h200;
            r.src  = (k % 2 == 0) ? 1'b0 : 1'b1;
            req_q.push_back(r);
        end
        hs = 0; ic_cd = -1; dc_cd = -1; rsp_n = 0;
        for (int c = 0; c < 80 && !(hs >= 6 && ic_cd < 0 && dc_cd < 0); c++) begin
            rv = 1'b0; rs = 1'b0; rd = '0;
            if (ic_cd == 0) begin rv = 1'b1; rs = 1'b0; ic_cd = -1; end
            else if (ic_cd > 0) ic_cd--;
            if (dc_cd == 0 && !rv) begin rv = 1'b1; rs = 1'b1; dc_cd = -1; end
            else if (dc_cd > 0) dc_cd--;
            if (rv) begin
                rd = {8{32'(32'hC0DE0000 + rsp_n)}};
                rsp_n++;
                p.src = rs; p.data = rd; rsp_q.push_back(p);
            end
            drive(hs < 6, 26'h100, hs < 6, 26'h200, 1'b1, rv, rs, rd);
            #1;
            if (mem_req_valid_o && mem_req_ready_i) begin
                hs++;
                if (mem_req_src_o) dc_cd = 2; else ic_cd = 2;
            end
            step();
        end
        chk("rr_handshakes", LB'(hs), LB'(6));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) step();
        chk("rr_req_q_empty", LB'(req_q.size()), LB'(0));
        chk("rr_rsp_q_empty", LB'(rsp_q.size()), LB'(0));

        // Memory backpressure: request held stable, no grants while stalled.
        do_reset();
        drive(1'b1, 26'h100, 1'b1, 26'h200, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("bp_ic_grant", LB'({ic_req_ready_o, dc_req_ready_o}), LB'(2'b10));
        r.addr = 26'h100; r.src = 1'b0; req_q.push_back(r);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 26'h100, 1'b1, 26'h200, 1'b0, 1'b0, 1'b0, '0);
            #1;
            chk($sformatf("bp%0d_mem_valid", k), LB'(mem_req_valid_o), LB'(1));
            chk($sformatf("bp%0d_addr", k), LB'(mem_req_addr_o), LB'(26'h100));
            chk($sformatf("bp%0d_src", k), LB'(mem_req_src_o), LB'(0));
            chk($sformatf("bp%0d_readies", k), LB'({ic_req_ready_o, dc_req_ready_o}), LB'(0));
            step();
        end
        drive(1'b1, 26'h100, 1'b1, 26'h200, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("bp_release_valid", LB'(mem_req_valid_o), LB'(1));
        step();
        drive(1'b1, 26'h100, 1'b1, 26'h200, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("bp_resume_dc_grant", LB'({ic_req_ready_o, dc_req_ready_o}), LB'(2'b01));
        step();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("issue_d_valid", LB'(mem_req_valid_o), LB'(1));
        chk("issue_d_addr", LB'(mem_req_addr_o), LB'(26'h200));
        chk("issue_d_src", LB'(mem_req_src_o), LB'(1));

        // Reset mid-ISSUE with I and D outstanding: everything clears at once.
        #1;
        reset = 1'b0;
        req_q.delete();
        rsp_q.delete();
        #1;
        chk("midrst_mem_valid", LB'(mem_req_valid_o), LB'(0));
        chk("midrst_addr", LB'(mem_req_addr_o), LB'(0));
        chk("midrst_src", LB'(mem_req_src_o), LB'(0));
        step();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, {8{32'h0BAD0BAD}});
        #1;
        chk("post_rst_spurious_low", LB'(spurious_o), LB'(0));
        step();
        drive(1'b1, 26'h300, 1'b1, 26'h400, 1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("stale_fill_spurious", LB'(spurious_o), LB'(1));
        chk("stale_fill_dropped", LB'({ic_resp_valid_o, dc_resp_valid_o}), LB'(0));
        chk("post_rst_tie_grant", LB'({ic_req_ready_o, dc_req_ready_o}), LB'(2'b10));
        r.addr = 26'h300; r.src = 1'b0; req_q.push_back(r);
        step();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        chk("post_rst_issue", LB'(mem_req_valid_o), LB'(1));
        step();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) step();
        chk("final_req_q_empty", LB'(req_q.size()), LB'(0));
        chk("final_spurious_sticky", LB'(spurious_o), LB'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
